// File: rtl/t08_fetch_pf_pkg.sv
// Shared types and defaults for the prefetching fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package t08_fetch_pkg;

  localparam int          FETCH_XLEN       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INC_DEFAULT      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // One prefetched instruction tagged with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/t08_fetch_pf_if.sv
// Instruction memory read bus: request held until a one-cycle ack strobe.
// Latency: set by the memory; data is valid in the ack cycle only.
// Backpressure: the requester holds req/addr stable until ack.
interface t08_fetch_pf_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/t08_fetch_queue.sv
// Prefetch FIFO of fetch_entry_t, head visible combinationally.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module t08_fetch_queue import t08_fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  fetch_entry_t   store [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = store[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush simply rewinds everything.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; needs no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) store[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/t08_fetch_pf.sv
// Fetch unit: PC, one-outstanding memory reads, DEPTH-entry prefetch queue, redirects.
// Latency: redirect -> IDLE (1) -> request (1) -> memory latency -> instr_valid (1).
// Backpressure: decode stalls via instr_ready; fetching pauses while the queue is full.
module t08_fetch_pf import t08_fetch_pkg::*; #(
  parameter int              XLEN     = FETCH_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              INC      = INC_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  t08_fetch_pf_if.master    mem,
  output logic              instr_valid,
  output logic [XLEN-1:0]   instr,
  output logic [XLEN-1:0]   instr_pc,
  input  logic              instr_ready,
  input  logic              branch,
  input  logic              jump,
  input  logic              jalr,
  input  logic [XLEN-1:0]   imm_address,
  input  logic [XLEN-1:0]   jalr_target,
  output logic [XLEN-1:0]   ret_address,
  output logic              misalign
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state, state_nxt;
  logic [XLEN-1:0]  fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0]  target;
  logic             redirect;
  logic             q_push, q_pop;
  logic             start_req, req_nxt;
  fetch_entry_t     head, push_entry;
  logic [CNT_W-1:0] count, count_after;
  logic             full, empty;

  // A redirect needs a real head instruction to be relative to.
  assign redirect    = instr_valid & (branch | jump | jalr);
  assign target      = jalr ? (jalr_target & ~XLEN'(1)) : (instr_pc + imm_address);
  assign q_pop       = instr_valid & instr_ready;
  assign q_push      = (state == WAIT) & mem.mem_ack & ~redirect;
  assign push_entry  = '{pc: fetch_pc, instr: mem.mem_rdata};
  assign count_after = count + CNT_W'(q_push) - CNT_W'(q_pop);

  assign instr_valid = ~empty;
  assign instr       = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;

  t08_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .nrst       (nrst),
    .push       (q_push),
    .pop        (q_pop),
    .flush      (redirect),
    .push_entry (push_entry),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: a request in flight at redirect time must be drained in DISCARD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!redirect && !full) state_nxt = WAIT;
      WAIT: begin
        if (redirect)          state_nxt = mem.mem_ack ? IDLE : DISCARD;
        else if (mem.mem_ack)  state_nxt = (count_after < CNT_W'(DEPTH)) ? WAIT : IDLE;
      end
      DISCARD: if (mem.mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: a new address is launched whenever we enter WAIT fresh.
  always_comb begin
    req_nxt      = (state_nxt != IDLE);
    start_req    = (state_nxt == WAIT) && ((state == IDLE) || mem.mem_ack);
    fetch_pc_nxt = fetch_pc;
    if (redirect)    fetch_pc_nxt = target;
    else if (q_push) fetch_pc_nxt = fetch_pc + XLEN'(INC);
  end

  // Registered request; reset drops it asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= RESET_PC;
    end else begin
      mem.mem_req <= req_nxt;
      if (start_req) mem.mem_addr <= fetch_pc_nxt;
    end
  end

  // PC, link register and misalignment pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fetch_pc    <= RESET_PC;
      ret_address <= '0;
      misalign    <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      misalign <= redirect && (target[1:0] != 2'b00);
      if (redirect && (jump || jalr)) ret_address <= instr_pc + XLEN'(INC);
    end
  end

endmodule

// File: tb/tb_t08_fetch_pf.sv
// Directed bench for t08_fetch_pf with a latency-programmable pc-tagged memory.
// Latency: memory acks mem_lat cycles after a request becomes visible.
// Backpressure: decode ready pulsed one pop at a time; memory can be held off.
module tb_t08_fetch_pf;
  import t08_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, ret_address;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, jalr = 1'b0;
  logic [31:0] imm_address = '0, jalr_target = '0;
  logic        misalign;

  int mem_lat  = 0;
  bit hold     = 1'b0;
  bit spurious = 1'b0;
  int n_chk    = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  t08_fetch_pf_if #(.XLEN(32)) mif ();

  t08_fetch_pf dut (
    .clk         (clk),
    .nrst        (nrst),
    .mem         (mif),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .branch      (branch),
    .jump        (jump),
    .jalr        (jalr),
    .imm_address (imm_address),
    .jalr_target (jalr_target),
    .ret_address (ret_address),
    .misalign    (misalign)
  );

  // Memory model: returns ~addr, acks mem_lat cycles after the request is seen.
  initial begin
    int cnt;
    cnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mif.mem_ack = 1'b0;
      if (!nrst) begin
        cnt = 0;
      end else if (spurious) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hBAD0_0000;
        spurious      = 1'b0;
      end else if (mif.mem_req && !hold) begin
        if (cnt >= mem_lat) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = ~mif.mem_addr;
          cnt           = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && !instr_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  // Consume one head and check its PC and pc-tagged instruction word.
  task automatic take(input string tag, input logic [31:0] pc);
    wait_valid(tag);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_instr"}, instr, ~pc);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    nrst        = 1'b0;
    instr_ready = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    jalr        = 1'b0;
    hold        = 1'b0;
    mem_lat     = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mem_req",  {31'd0, mif.mem_req}, 32'd0);
    chk("rst_mem_addr", mif.mem_addr, 32'h0);
    chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",    instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_ret",      ret_address, 32'h0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    nrst = 1'b1;

    // Sequential stream.
    for (int i = 0; i < 4; i++) take($sformatf("t1_%0d", i), 32'(i * 4));
    chk("t1_ret", ret_address, 32'h0);

    // Stall until full; a stray ack while idle must not be captured.
    do_reset();
    repeat (8) @(negedge clk);
    spurious = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_count", 32'(dut.u_queue.count), 32'd4);
    chk("t2_req",   {31'd0, mif.mem_req}, 32'd0);
    chk("t2_head",  instr_pc, 32'h0);
    for (int i = 0; i < 5; i++) take($sformatf("t2_%0d", i), 32'(i * 4));

    // Branch +10 from pc 8, then a branch with no head is ignored.
    do_reset();
    repeat (10) @(negedge clk);
    take("t3_a", 32'h0);
    take("t3_b", 32'h4);
    wait_valid("t3_pre");
    chk("t3_head", instr_pc, 32'h8);
    branch = 1'b1; imm_address = 32'd10;
    @(negedge clk);
    branch = 1'b0;
    chk("t3_flush", {31'd0, instr_valid}, 32'd0);
    chk("t3_mis",   {31'd0, misalign}, 32'd1);
    chk("t3_ret",   ret_address, 32'h0);
    branch = 1'b1; imm_address = 32'd100;
    @(negedge clk);
    branch = 1'b0;
    chk("t3_mis_clr", {31'd0, misalign}, 32'd0);
    take("t3_c", 32'd18);
    take("t3_d", 32'd22);

    // Jump -8 from pc 20 with a request outstanding; its late data is dropped.
    do_reset();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) take($sformatf("t4_%0d", i), 32'(i * 4));
    hold = 1'b1;
    @(negedge clk);
    chk("t4_head", instr_pc, 32'd20);
    chk("t4_req",  {31'd0, mif.mem_req}, 32'd1);
    jump = 1'b1; imm_address = 32'hFFFF_FFF8;
    @(negedge clk);
    jump = 1'b0;
    chk("t4_flush",    {31'd0, instr_valid}, 32'd0);
    chk("t4_req_held", {31'd0, mif.mem_req}, 32'd1);
    chk("t4_ret",      ret_address, 32'd24);
    chk("t4_mis",      {31'd0, misalign}, 32'd0);
    mem_lat = 3;
    hold    = 1'b0;

    // Stream on to pc 40, then jalr beats jump.
    for (int pc = 12; pc <= 36; pc += 4) take($sformatf("t5_%0d", pc), 32'(pc));
    wait_valid("t5_pre");
    chk("t5_head", instr_pc, 32'd40);
    jalr = 1'b1; jump = 1'b1; jalr_target = 32'h101; imm_address = 32'd8;
    @(negedge clk);
    jalr = 1'b0; jump = 1'b0;
    chk("t5_ret",   ret_address, 32'd44);
    chk("t5_mis",   {31'd0, misalign}, 32'd0);
    chk("t5_flush", {31'd0, instr_valid}, 32'd0);
    take("t5_a", 32'h100);
    take("t5_b", 32'h104);

    // Asynchronous reset while a request is waiting.
    hold = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_pre_req", {31'd0, mif.mem_req}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("t6_async_req",  {31'd0, mif.mem_req}, 32'd0);
    chk("t6_async_vld",  {31'd0, instr_valid}, 32'd0);
    chk("t6_async_addr", mif.mem_addr, 32'h0);
    chk("t6_async_ret",  ret_address, 32'h0);
    @(negedge clk);
    hold    = 1'b0;
    mem_lat = 0;
    nrst    = 1'b1;
    take("t6_a", 32'h0);
    take("t6_b", 32'h4);

    // jalr to a misaligned target near the top of memory: bit0 cleared, PC wraps.
    wait_valid("t7_pre");
    chk("t7_head", instr_pc, 32'h8);
    jalr = 1'b1; jalr_target = 32'hFFFF_FFFB;
    @(negedge clk);
    jalr = 1'b0;
    chk("t7_mis", {31'd0, misalign}, 32'd1);
    chk("t7_ret", ret_address, 32'hC);
    take("t7_a", 32'hFFFF_FFFA);
    take("t7_b", 32'hFFFF_FFFE);
    take("t7_c", 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/t08_fetch_pf.md
Name: t08_fetch_pf

Overview:
Parametrised successor to the team's single-cycle fetch unit. Holds the program counter and issues one-outstanding instruction reads over a req/ack memory handshake. Buffers returned words in a DEPTH-entry prefetch queue and presents them to decode with valid/ready. Applies branch/jump (PC-relative) and jalr (absolute) redirects with queue flush and in-flight discard, and produces the link (return) address.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch PC after reset
INC, 4, PC increment per instruction (bytes)

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
mem_req  output  1  read request, held until mem_ack
mem_addr  output  XLEN  read address, stable while mem_req=1
mem_ack  input  1  one-cycle response strobe; mem_rdata valid this cycle
mem_rdata  input  XLEN  instruction word
instr_valid  output  1  queue head valid
instr  output  XLEN  queue head instruction
instr_pc  output  XLEN  PC of queue head
instr_ready  input  1  decode consumes head when instr_valid=1
branch  input  1  taken branch, relative to instr_pc
jump  input  1  jal, relative to instr_pc, writes link
jalr  input  1  absolute jump, writes link
imm_address  input  XLEN  signed offset for branch/jump
jalr_target  input  XLEN  absolute target for jalr
ret_address  output  XLEN  link value, instr_pc+INC of last jump/jalr
misalign  output  1  one-cycle pulse: redirect target[1:0]!=0

Behaviour:
- Reset (async, nrst=0): fetch_pc=RESET_PC, queue empty, state IDLE, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, ret_address=0, misalign=0. mem_req drops immediately, without waiting for clk. An ack arriving after reset release with no request is ignored.
- FSM states: IDLE, WAIT, DISCARD.
- IDLE->WAIT: when count+0 < DEPTH and no redirect this cycle. mem_req=1, mem_addr=fetch_pc are registered, so the request is visible the next cycle.
- WAIT: on mem_ack, push {fetch_pc, mem_rdata} and set fetch_pc+=INC. Then go to WAIT again, with a new request next cycle, if count_after_push < DEPTH; otherwise go to IDLE.
- DISCARD: the request is still held; on mem_ack drop the data and go to IDLE. The new fetch at the redirected PC issues from IDLE.
- Redirect is accepted only when instr_valid=1, and consumes the head regardless of instr_ready.
- Redirect priority: jalr > jump > branch.
- Targets: branch/jump use instr_pc + imm_address, modulo 2^XLEN (wraps). jalr uses jalr_target with bit0 cleared.
- Redirect effects, all on the next edge: queue flushed, fetch_pc=target, and WAIT->DISCARD (if no mem_ack this cycle) or WAIT->IDLE (if mem_ack this cycle, data dropped). jump/jalr also load ret_address=instr_pc+INC; branch leaves ret_address unchanged.
- misalign=1 for one cycle if target[1:0]!=0. The target is still used as-is.
- Any of branch/jump/jalr asserted with instr_valid=0 is ignored, with no state change.
- Pop and push in the same cycle: count is unchanged, and the head is updated to the next entry.
- Queue full: no request issued. Exactly one request may be outstanding, so the queue never overflows.
- Redirect-to-first-instruction latency: 1 cycle to IDLE, then 1 cycle to mem_req, then the memory latency, then 1 cycle to instr_valid.
- fetch_pc wraps from 2^XLEN-INC to 0 silently.

Decomposition:
- Package t08_fetch_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, DISCARD}
  - fetch_entry_t struct {pc, instr}
  - localparams RESET_PC_DEFAULT and INC_DEFAULT
- Sub-module t08_fetch_queue: synchronous FIFO of fetch_entry_t with DEPTH entries.
  - Inputs: push, pop, flush. Outputs: head, count, full, empty.
  - Flush has priority over push and pop.

Test Plan:
- Reset, then a 1-cycle-latency ack memory returning pc-tagged words, instr_ready=1 -> instr_pc sequence 0,4,8,12,…; ret_address=0; mem_req=0 during reset.
- instr_ready=0 for 10 cycles -> count reaches 4 and mem_req stays 0. Release -> 4 heads are consumed in order, then fetch resumes at 16.
- Head instr_pc=8, branch=1, imm_address=10 -> next instr_pc=18, misalign pulses, ret_address unchanged, old queue entries never appear.
- Head instr_pc=20, jump=1, imm_address=-8 while a request is in WAIT, ack 3 cycles later -> the stale ack data is dropped, next instr_pc=12, ret_address=24.
- jalr=1 and jump=1 together, jalr_target=0x101, head pc=40 -> fetch at 0x100, ret_address=44, misalign=0.
- nrst pulsed low mid-WAIT -> mem_req=0 asynchronously, queue empty, fetch restarts at RESET_PC.
